// File: rtl/jk_pkg.sv
// jk_pkg
//   Shared types and helpers for the JK bank driver.
//   - state_t     : driver FSM states
//   - JK_* consts : two-bit {J,K} command encodings for one JK cell
//   - jk_excite() : excitation-table lookup for one cell, cur -> tgt
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Returns {J,K} that moves one cell from cur to tgt on the next strobe.
    // Toggle is only produced when use_toggle is set.
    function automatic logic [1:0] jk_excite(input logic cur,
                                             input logic tgt,
                                             input logic use_toggle);
        logic [1:0] cmd;
        if (cur == tgt) begin
            cmd = JK_HOLD;
        end else if (use_toggle) begin
            cmd = JK_TOGGLE;
        end else if (tgt) begin
            cmd = JK_SET;
        end else begin
            cmd = JK_RESET;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/jk_excite_enc.sv
// jk_excite_enc
//   Combinational per-bit JK excitation encoder for a bank of WIDTH cells.
//   Ports:
//     i_cur [WIDTH] : current cell outputs
//     i_tgt [WIDTH] : desired cell outputs
//     o_j   [WIDTH] : J command per cell
//     o_k   [WIDTH] : K command per cell
//   USE_TOGGLE=1 encodes changed bits as toggle, otherwise as set/reset.
module jk_excite_enc
    import jk_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int USE_TOGGLE = 0
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic [WIDTH-1:0] i_tgt,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k
);

    localparam logic TOGGLE_MODE = (USE_TOGGLE != 0);

    always_comb begin
        o_j = '0;
        o_k = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            {o_j[b], o_k[b]} = jk_excite(i_cur[b], i_tgt[b], TOGGLE_MODE);
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver
//   Write-side driver for a bank of WIDTH JK cells. Accepts a target word,
//   strobes the j/k commands that move the bank there, waits SETTLE_CYCLES,
//   reads the bank back and re-drives only the still-wrong bits up to
//   MAX_RETRY times before reporting err.
//   Ports:
//     clk, rst          : clock (rising edge), async active-high reset
//     tgt_data/valid    : requested bank contents and its valid
//     tgt_ready         : high while idle (accepting)
//     q_fb              : bank Q readback
//     j_out/k_out/jk_en : registered per-cell commands and one-cycle strobe
//     done / err        : one-cycle completion / retries-exhausted pulses
//     mismatch          : q_fb^target from the final failed compare
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 3,
    parameter int USE_TOGGLE    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             jk_en,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] mismatch
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    state_t           r_state;
    logic [WIDTH-1:0] r_tgt;
    logic [CNT_W-1:0] r_cnt;
    logic [RTY_W-1:0] r_retry;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic             r_en;
    logic             r_done;
    logic             r_err;
    logic [WIDTH-1:0] r_mismatch;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_tgt_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [RTY_W-1:0] w_retry_nxt;
    logic [WIDTH-1:0] w_j_nxt;
    logic [WIDTH-1:0] w_k_nxt;
    logic             w_en_nxt;
    logic             w_done_nxt;
    logic             w_err_nxt;
    logic [WIDTH-1:0] w_mismatch_nxt;

    logic [WIDTH-1:0] w_enc_tgt;
    logic [WIDTH-1:0] w_enc_j;
    logic [WIDTH-1:0] w_enc_k;

    // j/k are registered into the DRIVE cycle, so the encoder must see the
    // values being captured this edge: tgt_data when accepting, the held
    // target when re-driving from CHECK. The current state is always q_fb.
    assign w_enc_tgt = (r_state == IDLE) ? tgt_data : r_tgt;

    jk_excite_enc #(
        .WIDTH      (WIDTH),
        .USE_TOGGLE (USE_TOGGLE)
    ) u_enc (
        .i_cur (q_fb),
        .i_tgt (w_enc_tgt),
        .o_j   (w_enc_j),
        .o_k   (w_enc_k)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_tgt_nxt      = r_tgt;
        w_cnt_nxt      = r_cnt;
        w_retry_nxt    = r_retry;
        w_j_nxt        = '0;
        w_k_nxt        = '0;
        w_en_nxt       = 1'b0;
        w_done_nxt     = 1'b0;
        w_err_nxt      = 1'b0;
        w_mismatch_nxt = r_mismatch;

        case (r_state)
            IDLE: begin
                if (tgt_valid) begin
                    w_tgt_nxt      = tgt_data;
                    w_retry_nxt    = '0;
                    w_mismatch_nxt = '0;
                    if (q_fb == tgt_data) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = DRIVE;
                        w_j_nxt     = w_enc_j;
                        w_k_nxt     = w_enc_k;
                        w_en_nxt    = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (SETTLE_CYCLES > 0) begin
                    w_state_nxt = SETTLE;
                    w_cnt_nxt   = CNT_W'(SETTLE_CYCLES);
                end else begin
                    w_state_nxt = CHECK;
                end
            end
            SETTLE: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt <= CNT_W'(1)) begin
                    w_state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (q_fb == r_tgt) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_retry < RTY_W'(MAX_RETRY)) begin
                    w_retry_nxt = r_retry + RTY_W'(1);
                    w_state_nxt = DRIVE;
                    w_j_nxt     = w_enc_j;
                    w_k_nxt     = w_enc_k;
                    w_en_nxt    = 1'b1;
                end else begin
                    w_mismatch_nxt = q_fb ^ r_tgt;
                    w_err_nxt      = 1'b1;
                    w_state_nxt    = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_tgt      <= '0;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_j        <= '0;
            r_k        <= '0;
            r_en       <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_mismatch <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_tgt      <= w_tgt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_retry    <= w_retry_nxt;
            r_j        <= w_j_nxt;
            r_k        <= w_k_nxt;
            r_en       <= w_en_nxt;
            r_done     <= w_done_nxt;
            r_err      <= w_err_nxt;
            r_mismatch <= w_mismatch_nxt;
        end
    end

    assign tgt_ready = (r_state == IDLE);
    assign j_out     = r_j;
    assign k_out     = r_k;
    assign jk_en     = r_en;
    assign done      = r_done;
    assign err       = r_err;
    assign mismatch  = r_mismatch;

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Write-side driver for a bank of WIDTH JK storage cells: the producer of the j/k commands a JK cell consumes.
- Accepts a target word over a valid/ready handshake and samples the bank's current outputs.
- Converts each bit's current→target transition into j/k commands via the JK excitation table and issues one enable strobe.
- After a settle delay, reads the bank back and retries on mismatch; reports done or err.

Parameters:
- WIDTH, 8: number of JK cells driven.
- SETTLE_CYCLES, 2: idle cycles between strobe and readback compare; 0 allowed.
- MAX_RETRY, 3: re-drive attempts after the first strobe before err.
- USE_TOGGLE, 0: 1 = changed bits encoded 11 (toggle); 0 = changed bits encoded 10 (set) or 01 (reset).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tgt_data  input  WIDTH  requested bank contents.
- tgt_valid  input  1  tgt_data valid.
- tgt_ready  output  1  driver can accept; equals (state==IDLE).
- q_fb  input  WIDTH  bank Q outputs (readback).
- j_out  output  WIDTH  per-cell J command, registered.
- k_out  output  WIDTH  per-cell K command, registered.
- jk_en  output  1  one-cycle bank enable strobe, registered.
- done  output  1  one-cycle pulse: bank matches target.
- err  output  1  one-cycle pulse: retries exhausted.
- mismatch  output  WIDTH  q_fb^target captured at final failed compare; held until next accept.

Behaviour:
- Reset (async, immediate): state=IDLE; j_out=k_out=0; jk_en=done=err=0; mismatch=0; retry count=0; tgt_ready=1.
- Excitation per bit, cur→tgt:
  - 0→0 and 1→1: 00 (hold).
  - USE_TOGGLE=0: 0→1 = 10, 1→0 = 01.
  - USE_TOGGLE=1: 0→1 and 1→0 = 11.
  - 11 is never emitted when USE_TOGGLE=0.
- j_out and k_out are 0 in every state except DRIVE.
- IDLE:
  - On tgt_valid&&tgt_ready at edge T: capture tgt←tgt_data, cur←q_fb; clear retry count; clear mismatch.
  - If q_fb==tgt_data: no strobe; done=1 in cycle T+1; stay IDLE.
  - Else: go to DRIVE.
- DRIVE (one cycle, T+1): j_out/k_out=encode(cur,tgt); jk_en=1. Next state is SETTLE if SETTLE_CYCLES>0, else CHECK.
- SETTLE: counter loaded with SETTLE_CYCLES, decremented each cycle; exit to CHECK when the counter reaches 1. Occupies exactly SETTLE_CYCLES cycles.
- CHECK: compare q_fb with tgt.
  - Match: done=1 next cycle; return to IDLE.
  - Mismatch and retries<MAX_RETRY: retry++; cur←q_fb; go to DRIVE. Only still-wrong bits are driven.
  - Mismatch and retries==MAX_RETRY: mismatch←q_fb^tgt; err=1 next cycle; return to IDLE.
- Latency, successful first attempt: accept at T, jk_en at T+1, CHECK at T+2+SETTLE_CYCLES, done at T+3+SETTLE_CYCLES (T+5 with defaults).
- Strobe count: maximum 1+MAX_RETRY jk_en pulses per transaction.
- done and err are mutually exclusive, one cycle each. tgt_ready rises in the same cycle as done/err.
- tgt_valid while busy is ignored; tgt_data is not re-sampled mid-transaction.
- q_fb changes during SETTLE are ignored; only the CHECK-cycle value is used.
- rst mid-transaction: outputs clear immediately; no done or err is emitted; the transaction is lost.
- The bank is edge-triggered JK cells gated by jk_en. The driver never holds jk_en high for two consecutive cycles, so a toggle cannot oscillate.

Decomposition:
- Shared package jk_pkg:
  - State enum: IDLE, DRIVE, SETTLE, CHECK.
  - JK command constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
- One sub-module jk_excite_enc: combinational, WIDTH- and USE_TOGGLE-parameterised; cur,tgt → j,k.
- The FSM, counter and retry logic live in jk_bank_driver.

Test Plan (WIDTH=8, SETTLE_CYCLES=2, MAX_RETRY=3; bench models an ideal JK flip-flop bank updating on jk_en):
- USE_TOGGLE=0, q_fb=0x00, tgt=0xA5 accepted at T → at T+1 j_out=0xA5, k_out=0x00, jk_en=1 for one cycle; done=1 at T+5; err=0; bank reads 0xA5.
- q_fb=0xF0, tgt=0x3C, USE_TOGGLE=0 → j_out=0x0C, k_out=0xC0. Repeat with USE_TOGGLE=1 → j_out=k_out=0xCC. Both end with bank=0x3C and done.
- No-op: q_fb=0x5A, tgt=0x5A → jk_en never asserts; done=1 the cycle after accept; tgt_ready stays 1.
- Stuck cell: bank model forces bit3=0; q_fb=0x00, tgt=0xFF → exactly 4 jk_en pulses, first j_out=0xFF and retries j_out=0x08; then err=1, done=0, mismatch=0x08.
- rst asserted during SETTLE → j_out=k_out=jk_en=0 immediately; no done/err; after release tgt_ready=1 and a new tgt=0x11 completes normally.
- tgt_valid held high across two back-to-back words 0x0F then 0xF0 → each accepted only while tgt_ready=1; exactly two done pulses; final bank=0xF0.
